// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage: PCSEL codes, vectors,
// IR field layout and fetch FSM state encodings.
package cpu_pkg;

    localparam int unsigned IR_W     = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned LIT_W    = 16;
    localparam int unsigned PCSEL_W  = 3;
    localparam int unsigned STATE_W  = 2;

    localparam logic [PCSEL_W-1:0] PCSEL_PLUS4 = 3'd0;
    localparam logic [PCSEL_W-1:0] PCSEL_BR    = 3'd1;
    localparam logic [PCSEL_W-1:0] PCSEL_JMP   = 3'd2;
    localparam logic [PCSEL_W-1:0] PCSEL_ILLOP = 3'd3;
    localparam logic [PCSEL_W-1:0] PCSEL_XADR  = 3'd4;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h0000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h0000_0008;

    // RB overlays the top of LITERAL at IR[15:11]
    localparam int unsigned RB_LSB_IN_LIT = 11;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_EXEC  = 2'd2;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;   // IR[31:26]
        logic [REG_W-1:0]    rc;       // IR[25:21]
        logic [REG_W-1:0]    ra;       // IR[20:16]
        logic [LIT_W-1:0]    literal;  // IR[15:0]
    } ir_t;

    function automatic logic [REG_W-1:0] ir_rb(input ir_t ir);
        return ir.literal[RB_LSB_IN_LIT +: REG_W];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: IMEM req/ack handshake plus the decoded-instruction
// and retire interface toward control/datapath.
interface instr_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 32
);
    logic                IMEM_REQ;
    logic [PC_W-1:0]     IMEM_ADDR;
    logic                IMEM_ACK;
    logic [IR_W-1:0]     IMEM_RDATA;
    logic                INSTR_VALID;
    logic                INSTR_DONE;
    logic [PCSEL_W-1:0]  PCSEL;
    logic [PC_W-1:0]     JT;
    logic [OPCODE_W-1:0] OPCODE;
    logic [REG_W-1:0]    RC;
    logic [REG_W-1:0]    RA;
    logic [REG_W-1:0]    RB;
    logic [LIT_W-1:0]    LITERAL;
    logic [PC_W-1:0]     PC_OUT;
    logic [PC_W-1:0]     PC_PLUS4;

    modport master (
        output IMEM_REQ, IMEM_ADDR, INSTR_VALID,
        output OPCODE, RC, RA, RB, LITERAL, PC_OUT, PC_PLUS4,
        input  IMEM_ACK, IMEM_RDATA, INSTR_DONE, PCSEL, JT
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR, INSTR_VALID,
        input  OPCODE, RC, RA, RB, LITERAL, PC_OUT, PC_PLUS4,
        output IMEM_ACK, IMEM_RDATA, INSTR_DONE, PCSEL, JT
    );
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection from PC+4, branch offset, jump target and trap vectors.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int unsigned    PC_W      = 32,
    parameter logic [PC_W-1:0] ILLOP_VEC = PC_W'(ILLOP_VEC_DEF),
    parameter logic [PC_W-1:0] XADR_VEC  = PC_W'(XADR_VEC_DEF)
) (
    input  logic [PC_W-1:0]    pc_plus4,
    input  logic [PCSEL_W-1:0] pcsel,
    input  logic [LIT_W-1:0]   literal,
    input  logic [PC_W-1:0]    jt,
    output logic [PC_W-1:0]    next_pc_c
);

    logic [PC_W-1:0] br_off_c;

    always_comb begin
        br_off_c  = {{(PC_W-LIT_W-2){literal[LIT_W-1]}}, literal, 2'b00};
        next_pc_c = ILLOP_VEC;
        case (pcsel)
            PCSEL_PLUS4: next_pc_c = pc_plus4;
            PCSEL_BR:    next_pc_c = pc_plus4 + br_off_c;
            PCSEL_JMP:   next_pc_c = jt & ~PC_W'(3);
            PCSEL_ILLOP: next_pc_c = ILLOP_VEC;
            PCSEL_XADR:  next_pc_c = XADR_VEC;
            default:     next_pc_c = ILLOP_VEC;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC/IR registers, IMEM req/ack handshake and a
// two-phase FETCH/EXEC sequencer feeding the control ROM.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter logic [PC_W-1:0] ILLOP_VEC = PC_W'(ILLOP_VEC_DEF),
    parameter logic [PC_W-1:0] XADR_VEC  = PC_W'(XADR_VEC_DEF)
) (
    input  logic                CLK,
    input  logic                RESET,
    instr_fetch_unit_if.master  bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_plus4_q, pc_plus4_d;
    ir_t                ir_q, ir_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    next_pc_c;

    pc_next_mux #(
        .PC_W      (PC_W),
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_pc_next_mux (
        .pc_plus4  (pc_plus4_q),
        .pcsel     (bus.PCSEL),
        .literal   (ir_q.literal),
        .jt        (bus.JT),
        .next_pc_c (next_pc_c)
    );

    // Next-state: ACK only counts in FETCH, DONE only counts in EXEC
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        ir_d       = ir_q;
        req_d      = req_q;
        valid_d    = valid_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (bus.IMEM_ACK) begin
                    ir_d    = ir_t'(bus.IMEM_RDATA);
                    state_d = ST_EXEC;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (bus.INSTR_DONE) begin
                    pc_d       = next_pc_c;
                    pc_plus4_d = next_pc_c + PC_W'(4);
                    state_d    = ST_FETCH;
                    req_d      = 1'b1;
                    valid_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // PC+4 is kept as its own register so the link value is a flop output
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VEC;
            pc_plus4_q <= RESET_VEC + PC_W'(4);
            ir_q       <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            ir_q       <= ir_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.IMEM_REQ    = req_q;
    assign bus.IMEM_ADDR   = pc_q;
    assign bus.INSTR_VALID = valid_q;
    assign bus.OPCODE      = ir_q.opcode;
    assign bus.RC          = ir_q.rc;
    assign bus.RA          = ir_q.ra;
    assign bus.RB          = ir_rb(ir_q);
    assign bus.LITERAL     = ir_q.literal;
    assign bus.PC_OUT      = pc_q;
    assign bus.PC_PLUS4    = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch addresses are queued
// at retire time from a reference next-PC model and checked at each fetch.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_ir;

    instr_fetch_unit_if #(.PC_W(32)) bus ();

    instr_fetch_unit #(
        .PC_W      (32),
        .RESET_VEC (32'h0),
        .ILLOP_VEC (32'h4),
        .XADR_VEC  (32'h8)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [2:0] sel,
                                               input logic [31:0] ir, input logic [31:0] jt);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        case (sel)
            3'd0:    return p4;
            3'd1:    return p4 + {{14{ir[15]}}, ir[15:0], 2'b00};
            3'd2:    return {jt[31:2], 2'b00};
            3'd4:    return 32'h8;
            default: return 32'h4;
        endcase
    endfunction

    task automatic check_ir(input string tag);
        logic [31:0] p4;
        p4 = cur_pc + 32'd4;
        chk({tag, "_valid"},   32'(bus.INSTR_VALID), 32'd1);
        chk({tag, "_req"},     32'(bus.IMEM_REQ),    32'd0);
        chk({tag, "_opcode"},  32'(bus.OPCODE),      32'(cur_ir[31:26]));
        chk({tag, "_rc"},      32'(bus.RC),          32'(cur_ir[25:21]));
        chk({tag, "_ra"},      32'(bus.RA),          32'(cur_ir[20:16]));
        chk({tag, "_rb"},      32'(bus.RB),          32'(cur_ir[15:11]));
        chk({tag, "_literal"}, 32'(bus.LITERAL),     32'(cur_ir[15:0]));
        chk({tag, "_pc_out"},  bus.PC_OUT,           cur_pc);
        chk({tag, "_pc_plus4"}, bus.PC_PLUS4,        p4);
    endtask

    // One fetch: REQ/ADDR must hold through `waits` stalled cycles, then ACK
    task automatic fetch(input logic [31:0] data, input int waits, input bit done_in_fetch);
        logic [31:0] a;
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_req",   32'(bus.IMEM_REQ),    32'd1);
            chk("fetch_addr",  bus.IMEM_ADDR,        a);
            chk("fetch_valid", 32'(bus.INSTR_VALID), 32'd0);
            bus.INSTR_DONE = done_in_fetch;
            bus.PCSEL      = 3'd2;
            bus.JT         = 32'h0000_0F00;
            bus.IMEM_ACK   = (i == waits);
            bus.IMEM_RDATA = (i == waits) ? data : ~data;
            tick();
        end
        bus.IMEM_ACK   = 1'b0;
        bus.INSTR_DONE = 1'b0;
        bus.IMEM_RDATA = '0;
        cur_pc = a;
        cur_ir = data;
        check_ir("exec");
    endtask

    // Optional EXEC stall with spurious ACKs, then retire with the given PCSEL
    task automatic retire(input logic [2:0] sel, input logic [31:0] jt, input int stall);
        for (int i = 0; i < stall; i++) begin
            bus.IMEM_ACK   = 1'b1;
            bus.IMEM_RDATA = ~cur_ir;
            bus.INSTR_DONE = 1'b0;
            tick();
            check_ir("stall");
        end
        bus.IMEM_ACK = 1'b0;
        exp_q.push_back(model_next(cur_pc, sel, cur_ir, jt));
        bus.INSTR_DONE = 1'b1;
        bus.PCSEL      = sel;
        bus.JT         = jt;
        tick();
        bus.INSTR_DONE = 1'b0;
        bus.PCSEL      = 3'($urandom);
        bus.JT         = $urandom;
        chk("retire_valid", 32'(bus.INSTR_VALID), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.IMEM_ACK   = 1'b1;
        bus.IMEM_RDATA = 32'hA5A5_A5A5;
        bus.INSTR_DONE = 1'b0;
        bus.PCSEL      = 3'd0;
        bus.JT         = '0;

        // Reset held three cycles, ACK during reset ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pc_out", bus.PC_OUT,            32'h0);
            chk("rst_req",    32'(bus.IMEM_REQ),     32'd0);
            chk("rst_valid",  32'(bus.INSTR_VALID),  32'd0);
            chk("rst_opcode", 32'(bus.OPCODE),       32'd0);
        end
        rst          = 1'b0;
        bus.IMEM_ACK = 1'b0;
        chk("idle_req", 32'(bus.IMEM_REQ), 32'd0);
        tick();
        exp_q.push_back(32'h0);

        // Sequential zero-wait fetches 0,4,8,C
        fetch(32'h1234_5678, 0, 1'b0); retire(3'd0, 32'h0, 0);
        fetch(32'h8765_4321, 0, 1'b0); retire(3'd0, 32'h0, 0);
        fetch(32'hDEAD_BEEF, 0, 1'b0); retire(3'd0, 32'h0, 0);
        fetch(32'hC0DE_F00D, 0, 1'b0); retire(3'd0, 32'h0, 0);

        // Three wait states with INSTR_DONE asserted during FETCH
        fetch(32'h7FFF_0001, 3, 1'b1); retire(3'd2, 32'h0000_0100, 0);

        // Branch back, jump with low bits, undefined PCSEL, exception vector
        fetch(32'h6C22_FFFE, 0, 1'b0); retire(3'd1, 32'h0, 0);
        fetch(32'h1111_2222, 0, 1'b0); retire(3'd2, 32'h0000_0207, 0);
        fetch(32'h3333_4444, 1, 1'b0); retire(3'd6, 32'h0, 0);
        fetch(32'h5555_6666, 0, 1'b0); retire(3'd4, 32'h0, 0);
        fetch(32'h9ABC_DEF0, 0, 1'b0); retire(3'd3, 32'h0, 1);
        fetch(32'h0F0F_0F0F, 0, 1'b0); retire(3'd2, 32'hFFFF_FFFF, 2);

        // PC wrap at top of address space
        fetch(32'hFC00_8000, 0, 1'b0); retire(3'd0, 32'h0, 0);
        fetch(32'h2468_ACE0, 0, 1'b0); retire(3'd0, 32'h0, 0);

        // Reset while fetching at 0x4 with ACK in the same cycle
        chk("pre_rst_req",  32'(bus.IMEM_REQ), 32'd1);
        chk("pre_rst_addr", bus.IMEM_ADDR,     32'h4);
        void'(exp_q.pop_front());
        rst            = 1'b1;
        bus.IMEM_ACK   = 1'b1;
        bus.IMEM_RDATA = 32'hFFFF_FFFF;
        tick();
        rst          = 1'b0;
        bus.IMEM_ACK = 1'b0;
        chk("midrst_valid",   32'(bus.INSTR_VALID), 32'd0);
        chk("midrst_req",     32'(bus.IMEM_REQ),    32'd0);
        chk("midrst_opcode",  32'(bus.OPCODE),      32'd0);
        chk("midrst_literal", 32'(bus.LITERAL),     32'd0);
        chk("midrst_pc_out",  bus.PC_OUT,           32'h0);
        tick();
        chk("midrst_valid2",  32'(bus.INSTR_VALID), 32'd0);
        exp_q.push_back(32'h0);
        fetch(32'h4242_4242, 1, 1'b0); retire(3'd0, 32'h0, 0);
        fetch(32'h1357_9BDF, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
